// File: rtl/change_to_valid_pulse.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | change_to_valid_pulse: turns level changes or forced refreshes into       |
// | rate-limited, coalesced one-cycle valid pulses carrying the new value.    |
// | Revision: 1.0                                                              |
// +--------------------------------------------------------------------------+
module change_to_valid_pulse #(
  parameter type T          = logic,
  parameter int  MinGap     = 4,
  parameter T    ResetValue = T'('0)
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic en_i,
  input  T     data_i,
  input  logic force_i,
  output logic valid_o,
  output T     data_o,
  output logic pending_o,
  output logic coalesced_o
);

  localparam int GW = (MinGap > 1) ? $clog2(MinGap) : 1;

  if (MinGap < 1) begin : g_min_gap_check
    $error("change_to_valid_pulse: MinGap must be >= 1");
  end

  T            last_q, last_d;
  T            data_q, data_d;
  logic [GW-1:0] gap_q, gap_d;
  logic        fpend_q, fpend_d;
  logic        valid_q, valid_d;
  logic        coal_q, coal_d;

  logic chg, trig, gap_active;

  assign gap_active = (gap_q != '0);
  assign chg        = en_i && (data_i != last_q);
  assign trig       = chg || (en_i && (force_i || fpend_q));
  assign pending_o  = gap_active && trig;

  always_comb begin
    valid_d = 1'b0;
    coal_d  = 1'b0;
    data_d  = data_q;
    last_d  = last_q;
    gap_d   = gap_q;
    fpend_d = fpend_q;

    if (!gap_active) begin
      if (trig) begin
        valid_d = 1'b1;
        data_d  = data_i;
        last_d  = data_i;
        gap_d   = GW'(MinGap - 1);
        fpend_d = 1'b0;
      end
    end else begin
      // Data is not captured during the gap: gap end re-samples live data_i.
      gap_d = gap_q - GW'(1);
      if (en_i && force_i) fpend_d = 1'b1;
      if (trig)            coal_d  = 1'b1;
    end

    if (!en_i) fpend_d = 1'b0;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q <= 1'b0;
      coal_q  <= 1'b0;
      data_q  <= ResetValue;
      last_q  <= ResetValue;
      gap_q   <= '0;
      fpend_q <= 1'b0;
    end else begin
      valid_q <= valid_d;
      coal_q  <= coal_d;
      data_q  <= data_d;
      last_q  <= last_d;
      gap_q   <= gap_d;
      fpend_q <= fpend_d;
    end
  end

  assign valid_o     = valid_q;
  assign data_o      = data_q;
  assign coalesced_o = coal_q;

endmodule
`default_nettype wire

// File: tb/tb_change_to_valid_pulse.sv
`default_nettype none
// Directed-vector bench for change_to_valid_pulse (MinGap=4 main instance,
// MinGap=1 secondary instance for back-to-back pulses).
module tb_change_to_valid_pulse;

  typedef logic [7:0] byte_t;

  typedef struct {
    logic  en;
    logic  frc;
    byte_t d;
    logic  pend;   // pending_o during this cycle
    logic  v;      // valid_o after this cycle's edge
    byte_t dout;   // data_o after this cycle's edge
    logic  coal;   // coalesced_o after this cycle's edge
  } vec_t;

  logic  clk = 1'b0;
  logic  rst_n;
  logic  en;
  logic  frc;
  byte_t din;
  logic  valid, pending, coal;
  byte_t dout;
  logic  valid1, pending1, coal1;
  byte_t dout1;

  int n_vec = 0;
  int n_bad = 0;
  vec_t vq[$];
  int split_at;

  always #5 clk = ~clk;

  change_to_valid_pulse #(.T(byte_t), .MinGap(4), .ResetValue(8'd0)) dut (
    .clk_i(clk), .rst_ni(rst_n), .en_i(en), .data_i(din), .force_i(frc),
    .valid_o(valid), .data_o(dout), .pending_o(pending), .coalesced_o(coal)
  );

  change_to_valid_pulse #(.T(byte_t), .MinGap(1), .ResetValue(8'd0)) dut1 (
    .clk_i(clk), .rst_ni(rst_n), .en_i(en), .data_i(din), .force_i(frc),
    .valid_o(valid1), .data_o(dout1), .pending_o(pending1), .coalesced_o(coal1)
  );

  task automatic add(input logic e, input logic f, input byte_t d,
                     input logic p, input logic v, input byte_t o, input logic c);
    vec_t t;
    t.en = e; t.frc = f; t.d = d; t.pend = p; t.v = v; t.dout = o; t.coal = c;
    vq.push_back(t);
  endtask

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic apply(input int idx);
    logic p;
    logic [10:0] act, exp;
    @(negedge clk);
    en  = vq[idx].en;
    frc = vq[idx].frc;
    din = vq[idx].d;
    #1 p = pending;
    @(posedge clk);
    #1;
    act = {p, valid, dout, coal};
    exp = {vq[idx].pend, vq[idx].v, vq[idx].dout, vq[idx].coal};
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL vec%0d pend/valid/data/coal: got %b/%b/%0d/%b, expected %b/%b/%0d/%b",
               idx, act[10], act[9], act[8:1], act[0], exp[10], exp[9], exp[8:1], exp[0]);
    end
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b1; frc = 1'b0; din = 8'd0;

    // Steady data equal to the reset value never pulses.
    for (int i = 0; i < 100; i++) add(1, 0, 0, 0, 0, 0, 0);
    // Isolated change, then two changes coalesced into one pulse.
    add(1, 0, 5, 0, 1, 5, 0);
    add(1, 0, 5, 0, 0, 5, 0);
    add(1, 0, 6, 1, 0, 5, 1);
    add(1, 0, 7, 1, 0, 5, 1);
    add(1, 0, 7, 0, 1, 7, 0);
    for (int i = 0; i < 3; i++) add(1, 0, 7, 0, 0, 7, 0);
    // Change that reverts during the gap is dropped; force then refreshes.
    add(1, 0, 8, 0, 1, 8, 0);
    add(1, 0, 9, 1, 0, 8, 1);
    add(1, 0, 8, 0, 0, 8, 0);
    add(1, 0, 8, 0, 0, 8, 0);
    add(1, 0, 8, 0, 0, 8, 0);
    add(1, 1, 8, 0, 1, 8, 0);
    // Force inside the gap is latched and emitted at gap end.
    add(1, 1, 8, 1, 0, 8, 1);
    add(1, 0, 8, 1, 0, 8, 1);
    add(1, 0, 8, 1, 0, 8, 1);
    add(1, 0, 8, 0, 1, 8, 0);
    for (int i = 0; i < 3; i++) add(1, 0, 8, 0, 0, 8, 0);
    // Force and change together: exactly one pulse.
    add(1, 1, 4, 0, 1, 4, 0);
    for (int i = 0; i < 4; i++) add(1, 0, 4, 0, 0, 4, 0);
    // Latched force is discarded by en low; en rising emits the new value.
    add(1, 1, 4, 0, 1, 4, 0);
    add(1, 1, 4, 1, 0, 4, 1);
    add(0, 0, 3, 0, 0, 4, 0);
    add(0, 0, 3, 0, 0, 4, 0);
    add(0, 0, 3, 0, 0, 4, 0);
    add(1, 0, 4, 0, 0, 4, 0);
    add(0, 0, 3, 0, 0, 4, 0);
    add(1, 0, 3, 0, 1, 3, 0);
    split_at = vq.size();
    // After a mid-pulse reset the first change goes out immediately.
    add(1, 0, 3, 0, 1, 3, 0);
    add(1, 0, 3, 0, 0, 3, 0);
    add(1, 0, 3, 0, 0, 3, 0);

    repeat (2) @(posedge clk);
    #1;
    check("reset valid", valid, 0);
    check("reset data", dout, 0);
    check("reset coal", coal, 0);
    check("reset pending", pending, 0);
    @(negedge clk) rst_n = 1'b1;

    for (int i = 0; i < split_at; i++) apply(i);

    // valid_o is high here; reset must clear it without a clock edge.
    #2 rst_n = 1'b0;
    din = 8'd0;
    #1;
    check("async rst valid", valid, 0);
    check("async rst data", dout, 0);
    check("async rst coal", coal, 0);
    check("async rst pending", pending, 0);
    @(posedge clk);
    #1 check("held rst valid", valid, 0);
    @(negedge clk) rst_n = 1'b1;

    for (int i = split_at; i < vq.size(); i++) apply(i);

    // MinGap=1: every change pulses on the very next cycle.
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      en = 1'b1; frc = 1'b0; din = byte_t'(10 + k);
      #1 check("gap1 pending", pending1, 0);
      @(posedge clk);
      #1;
      check("gap1 valid", valid1, 1);
      check("gap1 data", dout1, 10 + k);
      check("gap1 coal", coal1, 0);
    end
    @(negedge clk);
    @(posedge clk);
    #1;
    check("gap1 idle valid", valid1, 0);
    check("gap1 hold data", dout1, 13);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/change_to_valid_pulse.md
# change_to_valid_pulse

Change detector that watches a level-valued input and emits a one-cycle, valid-only pulse carrying the new value whenever the value changes or a refresh is forced. Pulses are rate-limited by a minimum gap, and intermediate changes during the gap are coalesced so that only the latest value is emitted. The block sits directly upstream of `lossy_valid_to_stream`: its `valid_o`/`data_o` drive that block's `valid_i`/`data_i`, turning configuration or status updates into a backpressured stream. It has no ready input and never stalls.

## Interface
- `T`, `logic`: payload type.
- `MinGap`, `4`: minimum spacing in cycles between consecutive `valid_o` pulses. Must be ≥1; 0 is an elaboration error.
- `ResetValue`, `T'('0)`: reference value that `last` takes at reset, and the reset value of `data_o`.

Ports:
- `clk_i`  in  1  clock.
- `rst_ni`  in  1  reset; asynchronous, active-low.
- `en_i`  in  1  detection enable; when low, no triggers are recognised.
- `data_i`  in  T  monitored level value.
- `force_i`  in  1  request a pulse with the current `data_i` even if it is unchanged.
- `valid_o`  out  1  one-cycle pulse, registered.
- `data_o`  out  T  value emitted with the pulse, registered; holds its value between pulses.
- `pending_o`  out  1  combinational; a pulse is owed but blocked by the gap.
- `coalesced_o`  out  1  registered; one-cycle pulse whenever a trigger arrives while the gap is active.

## Operation
- State:
  - `last_q` (T): last emitted value.
  - `gap_q`: down-counter of width `max(1,$clog2(MinGap))`.
  - `fpend_q`: latched force.
  - Output registers for `valid_o`, `data_o`, `coalesced_o`.
- Combinational terms:
  - `chg = en_i && (data_i != last_q)`.
  - `trig = chg || (en_i && (force_i || fpend_q))`.
  - `pending_o = (gap_q != 0) && trig`.
- Decision cycle, when `gap_q == 0 && trig`:
  - `valid_o <= 1`, `data_o <= data_i`, `last_q <= data_i`.
  - `gap_q <= MinGap-1`, `fpend_q <= 0`.
- Gap active (`gap_q != 0`):
  - `gap_q` decrements by 1 each cycle.
  - If `en_i && force_i`, set `fpend_q <= 1`.
  - If `trig`, `coalesced_o <= 1`.
  - No data is stored: the value emitted at gap end is the live `data_i` at that cycle.
- Emission at gap end:
  - A change that reverts to `last_q` before the gap ends produces no pulse, unless `fpend_q` is set.
  - A latched force produces a pulse even when `data_i == last_q`.
- `en_i` low:
  - No triggers are recognised and `fpend_q` is cleared.
  - `gap_q` keeps counting down.
- Force and change in the same cycle produce exactly one pulse.
- `valid_o` and `coalesced_o` default to 0 in every cycle in which they are not set.

## Timing
- Reset values:
  - `valid_o=0`, `coalesced_o=0`, `data_o=ResetValue`.
  - `last_q=ResetValue`, `gap_q=0`, `fpend_q=0`.
  - `pending_o` follows from these values: it is 0 while `gap_q=0`.
- Reset asserts asynchronously and clears all state immediately, including mid-gap and during a pulse.
- Latency: trigger in decision cycle d gives `valid_o` high in cycle d+1, for exactly one cycle.
- Spacing: the next possible decision cycle is d+MinGap.
  - With `MinGap=1`, back-to-back pulses are allowed on every cycle `data_i` changes.
- Coalesced triggers are emitted at cycle d+MinGap, so `valid_o` rises at d+MinGap+1.
- After reset release with `en_i=1` and `data_i != ResetValue`:
  - The first active cycle is a decision cycle.
  - `valid_o` rises on the following cycle.
- Counter width rule: `gap_q` never underflows, and it is only loaded in a decision cycle.

## Test plan
- Reset, `ResetValue=0`, `data_i=0`, `en_i=1` for 100 cycles -> `valid_o` never asserts, `data_o=0`, `pending_o=0`.
- `MinGap=4`, `data_i` changes 0→5 at cycle 10 -> `valid_o=1` only in cycle 11 with `data_o=5`, and `data_o` stays 5 afterwards.
- Continuing, `data_i` changes to 6 at cycle 12 and to 7 at cycle 13 -> `coalesced_o` high in cycles 13 and 14, `pending_o` high in 12–13, single pulse in cycle 15 with `data_o=7`.
- Pulse with 8 decided at cycle 20, then `data_i`=9 at 21 and back to 8 at 22 -> `coalesced_o` at 22, no `valid_o` at 25; then `force_i` at 26 with unchanged data -> pulse at 27 with `data_o=8`.
- `force_i` during the gap with data unchanged -> one pulse at gap end carrying `last_q`. Force and change together in a free cycle -> exactly one pulse.
- `en_i=0` while `data_i` changes 8→3 -> no pulse and `fpend_q` cleared; `en_i` rises at cycle t -> pulse at t+1 with 3.
- Reset asserted mid-gap -> all outputs return to reset values immediately, and the first post-reset change is emitted without waiting out the old gap.
